// File: rtl/usb_bus_initiator_pkg.sv
// Shared definitions for the USB register-bus initiator: FSM states, phase-counter width
// and the address/data widths that the register-bus responder also uses.
package usb_bus_initiator_pkg;

    localparam int PHASE_W    = 4;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int BYTE_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ALE,
        SETUP,
        STROBE,
        HOLD,
        WAIT
    } bus_state_t;

    // The phase timer reports done once it has counted down to zero, so an
    // N-cycle phase is loaded with N-1.
    function automatic logic [PHASE_W-1:0] phase_preload(input int cycles);
        return PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/usb_bus_phase_timer.sv
// Loadable down-counter shared by the ALE, SETUP, STROBE and HOLD phases.
// done is high while the count is zero; it stays at zero until reloaded.
module usb_bus_phase_timer
    import usb_bus_initiator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic               done
);

    logic [PHASE_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - PHASE_W'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/usb_bus_initiator.sv
// Drives the ChipWhisperer USB register bus (address latch, then one data strobe per byte)
// from a command handshake plus byte streams; one burst per command, address held constant.
module usb_bus_initiator
    import usb_bus_initiator_pkg::*;
#(
    parameter int ALE_CYCLES   = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 3,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  clk_usb,
    input  logic                  reset_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [BYTE_CNT_W-1:0] cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic [ADDR_W-1:0]     usb_addr,
    output logic [DATA_W-1:0]     usb_d_o,
    output logic                  usb_d_oe,
    input  logic [DATA_W-1:0]     usb_d_i,
    output logic                  usb_cen,
    output logic                  usb_alen,
    output logic                  usb_rdn,
    output logic                  usb_wrn
);

    localparam logic [PHASE_W-1:0] ALE_LD   = phase_preload(ALE_CYCLES);
    localparam logic [PHASE_W-1:0] SETUP_LD = phase_preload(SETUP_CYCLES);
    localparam logic [PHASE_W-1:0] PULSE_LD = phase_preload(PULSE_CYCLES);
    localparam logic [PHASE_W-1:0] HOLD_LD  = phase_preload(HOLD_CYCLES);
    // With no setup phase a byte starts directly with the strobe.
    localparam logic [PHASE_W-1:0] BYTE_LD    = (SETUP_CYCLES == 0) ? PULSE_LD : SETUP_LD;
    localparam bus_state_t         BYTE_STATE = (SETUP_CYCLES == 0) ? STROBE : SETUP;

    bus_state_t              state_reg;
    logic                    write_reg;
    logic [BYTE_CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]       wbuf_reg;
    logic                    wbuf_full_reg;
    logic                    rdata_pend_reg;

    logic                    phase_load;
    logic [PHASE_W-1:0]      phase_val;
    logic                    phase_done;
    logic                    start_byte;
    logic                    byte_in;
    logic                    have_byte;
    logic                    rd_stall;
    logic                    more_bytes;

    usb_bus_phase_timer u_phase_timer (
        .clk      (clk_usb),
        .rst      (reset_i),
        .load     (phase_load),
        .load_val (phase_val),
        .done     (phase_done)
    );

    assign byte_in   = wdata_ready & wdata_valid;
    assign have_byte = wbuf_full_reg | byte_in;
    // A captured byte is in flight for one cycle before rdata_valid rises.
    assign rd_stall  = rdata_pend_reg | (rdata_valid & ~rdata_ready);
    // cnt_reg counts bytes still owed after the current one; HOLD has not decremented yet.
    assign more_bytes = (state_reg == HOLD) ? (cnt_reg != BYTE_CNT_W'(1)) : (cnt_reg != '0);

    always_comb begin
        phase_load = 1'b0;
        phase_val  = '0;
        start_byte = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    phase_load = 1'b1;
                    phase_val  = ALE_LD;
                end
            end
            ALE:    start_byte = phase_done && (!write_reg || have_byte);
            WAIT:   start_byte = have_byte;
            SETUP: begin
                phase_load = phase_done;
                phase_val  = PULSE_LD;
            end
            STROBE: begin
                phase_load = phase_done;
                phase_val  = HOLD_LD;
            end
            HOLD:   start_byte = phase_done && (cnt_reg != '0) && (write_reg ? have_byte : !rd_stall);
            default: ;
        endcase
        if (start_byte) begin
            phase_load = 1'b1;
            phase_val  = BYTE_LD;
        end
    end

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            state_reg      <= IDLE;
            write_reg      <= 1'b0;
            cnt_reg        <= '0;
            wbuf_reg       <= '0;
            wbuf_full_reg  <= 1'b0;
            rdata_pend_reg <= 1'b0;
            cmd_ready      <= 1'b0;
            wdata_ready    <= 1'b0;
            rdata_valid    <= 1'b0;
            rdata          <= '0;
            busy           <= 1'b0;
            usb_addr       <= '0;
            usb_d_o        <= '0;
            usb_d_oe       <= 1'b0;
            usb_cen        <= 1'b1;
            usb_alen       <= 1'b1;
            usb_rdn        <= 1'b1;
            usb_wrn        <= 1'b1;
        end else begin
            if (byte_in) begin
                wbuf_reg      <= wdata;
                wbuf_full_reg <= 1'b1;
                wdata_ready   <= 1'b0;
            end

            // A new capture wins over a simultaneous consumer accept.
            if (rdata_pend_reg) begin
                rdata_valid    <= 1'b1;
                rdata_pend_reg <= 1'b0;
            end else if (rdata_valid && rdata_ready) begin
                rdata_valid <= 1'b0;
            end

            if (start_byte) begin
                if (state_reg == HOLD) begin
                    cnt_reg <= cnt_reg - BYTE_CNT_W'(1);
                end
                state_reg <= BYTE_STATE;
                usb_alen  <= 1'b1;
                usb_d_oe  <= write_reg;
                if (write_reg) begin
                    usb_d_o       <= byte_in ? wdata : wbuf_reg;
                    wbuf_full_reg <= 1'b0;
                    wdata_ready   <= more_bytes;
                end
                if (SETUP_CYCLES == 0) begin
                    usb_wrn <= ~write_reg;
                    usb_rdn <= write_reg;
                end
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        cmd_ready <= 1'b1;
                        if (cmd_valid && cmd_ready) begin
                            state_reg     <= ALE;
                            write_reg     <= cmd_write;
                            cnt_reg       <= cmd_len;
                            wbuf_full_reg <= 1'b0;
                            usb_addr      <= cmd_addr;
                            usb_cen       <= 1'b0;
                            usb_alen      <= 1'b0;
                            busy          <= 1'b1;
                            cmd_ready     <= 1'b0;
                            wdata_ready   <= cmd_write;
                        end
                    end
                    ALE: begin
                        // Only a write with no byte on hand gets here.
                        if (phase_done) begin
                            usb_alen  <= 1'b1;
                            state_reg <= WAIT;
                        end
                    end
                    WAIT: ;
                    SETUP: begin
                        if (phase_done) begin
                            state_reg <= STROBE;
                            usb_wrn   <= ~write_reg;
                            usb_rdn   <= write_reg;
                        end
                    end
                    STROBE: begin
                        if (phase_done) begin
                            state_reg <= HOLD;
                            usb_wrn   <= 1'b1;
                            usb_rdn   <= 1'b1;
                            if (!write_reg) begin
                                rdata          <= usb_d_i;
                                rdata_pend_reg <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (phase_done) begin
                            if (cnt_reg == '0) begin
                                state_reg <= IDLE;
                                usb_cen   <= 1'b1;
                                usb_d_oe  <= 1'b0;
                                busy      <= 1'b0;
                                cmd_ready <= 1'b1;
                            end else if (write_reg) begin
                                cnt_reg   <= cnt_reg - BYTE_CNT_W'(1);
                                state_reg <= WAIT;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_bus_initiator.sv
// Directed bench for usb_bus_initiator: default-timing instance A for writes, reads, stalls
// and reset; instance B with zero setup / one-cycle pulses for a 256-byte read burst.
module tb_usb_bus_initiator;

    logic clk;
    logic rst;

    logic       a_cmd_valid, a_cmd_ready, a_cmd_write;
    logic [7:0] a_cmd_addr, a_cmd_len;
    logic       a_wdata_valid, a_wdata_ready;
    logic [7:0] a_wdata;
    logic       a_rdata_valid, a_rdata_ready;
    logic [7:0] a_rdata;
    logic       a_busy;
    logic [7:0] a_usb_addr, a_usb_d_o, a_usb_d_i;
    logic       a_usb_d_oe, a_usb_cen, a_usb_alen, a_usb_rdn, a_usb_wrn;

    logic       b_cmd_valid, b_cmd_ready, b_cmd_write;
    logic [7:0] b_cmd_addr, b_cmd_len;
    logic       b_wdata_valid, b_wdata_ready;
    logic [7:0] b_wdata;
    logic       b_rdata_valid, b_rdata_ready;
    logic [7:0] b_rdata;
    logic       b_busy;
    logic [7:0] b_usb_addr, b_usb_d_o, b_usb_d_i;
    logic       b_usb_d_oe, b_usb_cen, b_usb_alen, b_usb_rdn, b_usb_wrn;

    int checks = 0;
    int errors = 0;

    logic [7:0] wq[$];
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];

    logic [7:0] a_base = 8'h00;
    logic [7:0] a_idx  = 8'h00;
    logic [7:0] b_idx  = 8'h00;
    int a_rd_pulses = 0, a_ale_pulses = 0, a_viol = 0;
    int a_rd_w = 0, a_wr_w = 0, a_ale_w = 0;
    logic [7:0] a_wr_byte = 8'h00;
    logic       a_wr_oe = 1'b0;
    int b_rd_pulses = 0, b_rd_w = 0, b_viol = 0;

    assign a_usb_d_i = a_base + a_idx;
    assign b_usb_d_i = (b_idx * 8'd7) + 8'd3;

    usb_bus_initiator u_dut_a (
        .clk_usb(clk), .reset_i(rst),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
        .cmd_addr(a_cmd_addr), .cmd_len(a_cmd_len),
        .wdata_valid(a_wdata_valid), .wdata_ready(a_wdata_ready), .wdata(a_wdata),
        .rdata_valid(a_rdata_valid), .rdata_ready(a_rdata_ready), .rdata(a_rdata),
        .busy(a_busy), .usb_addr(a_usb_addr),
        .usb_d_o(a_usb_d_o), .usb_d_oe(a_usb_d_oe), .usb_d_i(a_usb_d_i),
        .usb_cen(a_usb_cen), .usb_alen(a_usb_alen), .usb_rdn(a_usb_rdn), .usb_wrn(a_usb_wrn)
    );

    usb_bus_initiator #(
        .ALE_CYCLES(2), .SETUP_CYCLES(0), .PULSE_CYCLES(1), .HOLD_CYCLES(1)
    ) u_dut_b (
        .clk_usb(clk), .reset_i(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len),
        .wdata_valid(b_wdata_valid), .wdata_ready(b_wdata_ready), .wdata(b_wdata),
        .rdata_valid(b_rdata_valid), .rdata_ready(b_rdata_ready), .rdata(b_rdata),
        .busy(b_busy), .usb_addr(b_usb_addr),
        .usb_d_o(b_usb_d_o), .usb_d_oe(b_usb_d_oe), .usb_d_i(b_usb_d_i),
        .usb_cen(b_usb_cen), .usb_alen(b_usb_alen), .usb_rdn(b_usb_rdn), .usb_wrn(b_usb_wrn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while (a_busy && n < maxc) begin
            tick;
            n++;
        end
        chk(tag, 32'(a_busy), 0);
    endtask

    // Instance A bus monitor, responder and read-stream scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            a_rd_w = 0; a_wr_w = 0; a_ale_w = 0;
        end else begin
            if (!a_usb_rdn && !a_usb_wrn) a_viol++;
            if (!a_usb_rdn && a_usb_d_oe) a_viol++;
            if (a_busy && a_usb_cen) a_viol++;
            if (!a_usb_alen) a_ale_w++;
            else if (a_ale_w != 0) begin
                chk("a_ale_width", a_ale_w, 2);
                a_ale_pulses++;
                a_ale_w = 0;
            end
            if (!a_usb_wrn) begin
                a_wr_w++;
                a_wr_byte = a_usb_d_o;
                a_wr_oe = a_usb_d_oe;
            end else if (a_wr_w != 0) begin
                chk("a_wr_width", a_wr_w, 3);
                chk("a_wr_oe", 32'(a_wr_oe), 1);
                chk("a_wr_expected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) chk("a_wr_data", 32'(a_wr_byte), 32'(wq.pop_front()));
                a_wr_w = 0;
            end
            if (!a_usb_rdn) a_rd_w++;
            else if (a_rd_w != 0) begin
                chk("a_rd_width", a_rd_w, 3);
                a_rd_pulses++;
                a_idx = a_idx + 8'd1;
                a_rd_w = 0;
            end
            if (a_rdata_valid && a_rdata_ready) begin
                chk("a_rd_expected", 32'(sb_a.size() > 0), 1);
                if (sb_a.size() > 0) chk("a_rd_data", 32'(a_rdata), 32'(sb_a.pop_front()));
            end
        end
    end

    // Instance B: one-cycle pulse check, responder and read-stream scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            b_rd_w = 0;
        end else begin
            if (!b_usb_rdn && (b_usb_d_oe || !b_usb_wrn)) b_viol++;
            if (!b_usb_rdn) b_rd_w++;
            else if (b_rd_w != 0) begin
                chk("b_rd_width", b_rd_w, 1);
                b_rd_pulses++;
                b_idx = b_idx + 8'd1;
                b_rd_w = 0;
            end
            if (b_rdata_valid && b_rdata_ready) begin
                chk("b_rd_expected", 32'(sb_b.size() > 0), 1);
                if (sb_b.size() > 0) chk("b_rd_data", 32'(b_rdata), 32'(sb_b.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        a_cmd_valid = 0; a_cmd_write = 0; a_cmd_addr = 0; a_cmd_len = 0;
        a_wdata_valid = 0; a_wdata = 0; a_rdata_ready = 1;
        b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = 0; b_cmd_len = 0;
        b_wdata_valid = 0; b_wdata = 0; b_rdata_ready = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({a_usb_cen, a_usb_alen, a_usb_rdn, a_usb_wrn}), 'hF);
        chk("rst_oe", 32'(a_usb_d_oe), 0);
        chk("rst_addr_do", 32'({a_usb_addr, a_usb_d_o}), 0);
        chk("rst_rdata", 32'({a_rdata_valid, a_rdata}), 0);
        chk("rst_busy_ready", 32'({a_busy, a_cmd_ready}), 0);
        rst = 1'b0;
        tick;
        chk("idle_cmd_ready", 32'(a_cmd_ready), 1);

        // Single-byte write, default timing
        a_cmd_valid = 1; a_cmd_write = 1; a_cmd_addr = 8'h2A; a_cmd_len = 0;
        a_wdata_valid = 1; a_wdata = 8'h5C;
        wq.push_back(8'h5C);
        tick;                                   // E0: accepted
        a_cmd_valid = 0;
        chk("t1_alen_low", 32'(a_usb_alen), 0);
        chk("t1_addr", 32'(a_usb_addr), 'h2A);
        chk("t1_cen_busy", 32'({a_usb_cen, a_busy, a_cmd_ready}), 'b010);
        tick;                                   // E1: byte taken
        a_wdata_valid = 0;
        chk("t1_alen_low2", 32'(a_usb_alen), 0);
        chk("t1_wready_drop", 32'(a_wdata_ready), 0);
        tick;                                   // E2: SETUP
        chk("t1_setup", 32'({a_usb_alen, a_usb_d_oe, a_usb_wrn}), 'b111);
        chk("t1_do", 32'(a_usb_d_o), 'h5C);
        tick;                                   // E3: strobe low
        chk("t1_wrn_fall", 32'(a_usb_wrn), 0);
        repeat (3) tick;                        // E6: HOLD
        chk("t1_hold", 32'({a_usb_wrn, a_usb_d_oe, a_busy}), 'b111);
        tick;                                   // E7: release
        chk("t1_release", 32'({a_usb_cen, a_busy, a_usb_d_oe, a_cmd_ready}), 'b1001);
        chk("t1_wq_empty", wq.size(), 0);

        // Read len 3, responder A0..A3
        a_base = 8'hA0; a_idx = 0; a_rd_pulses = 0; a_ale_pulses = 0;
        for (int k = 0; k < 4; k++) sb_a.push_back(8'(8'hA0 + k));
        a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 8'h10; a_cmd_len = 3;
        tick;
        a_cmd_valid = 0;
        chk("t2_addr", 32'(a_usb_addr), 'h10);
        wait_a_idle("t2_timeout", 200);
        repeat (3) tick;
        chk("t2_rd_pulses", a_rd_pulses, 4);
        chk("t2_ale_pulses", a_ale_pulses, 1);
        chk("t2_sb_empty", sb_a.size(), 0);

        // Write len 1, second byte withheld
        wq.push_back(8'h11); wq.push_back(8'h22);
        a_cmd_valid = 1; a_cmd_write = 1; a_cmd_addr = 8'h05; a_cmd_len = 1;
        a_wdata_valid = 1; a_wdata = 8'h11;
        tick;
        a_cmd_valid = 0;
        tick;
        a_wdata_valid = 0;
        n = 0;
        while (a_usb_wrn && n < 20) begin tick; n++; end
        while (!a_usb_wrn && n < 40) begin tick; n++; end
        chk("t3_first_strobe_timeout", 32'(n < 40), 1);
        repeat (5) begin
            tick;
            chk("t3_wait_wrn", 32'({a_usb_wrn, a_usb_cen}), 'b10);
        end
        chk("t3_wready_waiting", 32'(a_wdata_ready), 1);
        a_wdata_valid = 1; a_wdata = 8'h22;
        tick;
        a_wdata_valid = 0;
        chk("t3_setup_after_accept", 32'({a_usb_wrn, a_usb_d_oe}), 'b11);
        chk("t3_do", 32'(a_usb_d_o), 'h22);
        tick;
        chk("t3_wrn_fall", 32'(a_usb_wrn), 0);
        wait_a_idle("t3_timeout", 50);
        tick;
        chk("t3_wq_empty", wq.size(), 0);

        // Read len 1 with the consumer stalled for 10 cycles
        a_rdata_ready = 0;
        a_base = 8'hB0; a_idx = 0; a_rd_pulses = 0;
        sb_a.push_back(8'hB0); sb_a.push_back(8'hB1);
        a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 8'h20; a_cmd_len = 1;
        tick;
        a_cmd_valid = 0;
        n = 0;
        while (!a_rdata_valid && n < 30) begin tick; n++; end
        chk("t4_valid_timeout", 32'(a_rdata_valid), 1);
        repeat (10) tick;
        chk("t4_one_pulse", a_rd_pulses, 1);
        chk("t4_held", 32'({a_rdata_valid, a_usb_rdn, a_usb_cen}), 'b110);
        chk("t4_rdata", 32'(a_rdata), 'hB0);
        a_rdata_ready = 1;
        wait_a_idle("t4_timeout", 50);
        repeat (3) tick;
        chk("t4_two_pulses", a_rd_pulses, 2);
        chk("t4_sb_empty", sb_a.size(), 0);

        // Reset during the write strobe
        a_cmd_valid = 1; a_cmd_write = 1; a_cmd_addr = 8'h33; a_cmd_len = 0;
        a_wdata_valid = 1; a_wdata = 8'h77;
        tick;
        a_cmd_valid = 0;
        tick;
        a_wdata_valid = 0;
        n = 0;
        while (a_usb_wrn && n < 20) begin tick; n++; end
        chk("t5_in_strobe", 32'(a_usb_wrn), 0);
        #2 rst = 1'b1;
        #1;
        chk("t5_strobes_high", 32'({a_usb_wrn, a_usb_cen, a_usb_alen, a_usb_rdn}), 'hF);
        chk("t5_oe_busy", 32'({a_usb_d_oe, a_busy, a_rdata_valid}), 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick;
        chk("t5_cmd_ready", 32'(a_cmd_ready), 1);
        chk("t5_wready", 32'(a_wdata_ready), 0);

        // Instance B: zero setup, one-cycle pulses, 256-byte read
        b_idx = 0; b_rd_pulses = 0;
        for (int k = 0; k < 256; k++) sb_b.push_back(8'(k * 7 + 3));
        b_cmd_valid = 1; b_cmd_write = 0; b_cmd_addr = 8'h33; b_cmd_len = 8'd255;
        tick;
        b_cmd_valid = 0;
        chk("t6_addr", 32'(b_usb_addr), 'h33);
        n = 0;
        while (b_busy && n < 4000) begin tick; n++; end
        chk("t6_timeout", 32'(b_busy), 0);
        repeat (4) tick;
        chk("t6_pulses", b_rd_pulses, 256);
        chk("t6_sb_empty", sb_b.size(), 0);
        chk("t6_idle", 32'({b_cmd_ready, b_usb_cen, b_usb_alen, b_usb_wrn, b_wdata_ready}), 'b11110);
        chk("t6_do_untouched", 32'(b_usb_d_o), 0);
        repeat (5) tick;
        chk("t6_no_extra", b_rd_pulses, 256);
        chk("b_invariants", b_viol, 0);
        chk("a_invariants", a_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
